// File: rtl/dctlb_tlbi_seq.sv
// dctlb_tlbi_seq: buffers l2tlb TLBI messages and issues masked compare-invalidate commands to the dctlb, then acks.
// Ports: clk/reset; tlbi_valid/tlbi_retry/tlbi_kind/tlbi_vpn (from l2tlb);
// inv_valid/inv_retry/inv_index/inv_vpn/inv_mask (to dctlb array); ack_valid/ack_retry (to l2tlb).
module dctlb_tlbi_seq #(
  parameter int VPN_BITS   = 27,
  parameter int IDX_BITS   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tlbi_valid,
  output logic                tlbi_retry,
  input  logic [1:0]          tlbi_kind,
  input  logic [VPN_BITS-1:0] tlbi_vpn,
  output logic                inv_valid,
  input  logic                inv_retry,
  output logic [IDX_BITS-1:0] inv_index,
  output logic [VPN_BITS-1:0] inv_vpn,
  output logic [VPN_BITS-1:0] inv_mask,
  output logic                ack_valid,
  input  logic                ack_retry
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NS = (VPN_BITS + IDX_BITS - 1) / IDX_BITS;
  typedef enum logic [1:0] {IDLE, SINGLE, SWEEP, ACK} state_t;
  state_t state;
  logic [1:0] fk [FIFO_DEPTH];
  logic [VPN_BITS-1:0] fv [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [IDX_BITS-1:0] sweep_cnt, hash;
  logic [1:0] hk;
  logic [VPN_BITS-1:0] hv, mask;
  logic [NS*IDX_BITS-1:0] ext;
  logic [4:0] sh;
  logic push, pop;
  assign tlbi_retry = cnt == (PW+1)'(FIFO_DEPTH);
  assign push = tlbi_valid && !tlbi_retry;
  assign pop = state == IDLE && cnt != '0;
  assign hk = fk[rp];
  assign hv = fv[rp];
  // Index hash over the head entry: XOR of IDX_BITS-wide VPN slices, top slice zero-extended.
  always_comb begin
    ext = '0;
    ext[VPN_BITS-1:0] = hv;
    hash = '0;
    for (int i = 0; i < NS; i++) hash = hash ^ ext[i*IDX_BITS +: IDX_BITS];
    sh = hk == 2'd0 ? 5'd0 : hk == 2'd1 ? 5'd9 : hk == 2'd2 ? 5'd10 : 5'd18;
    mask = {VPN_BITS{1'b1}} << sh;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fk[wp] <= tlbi_kind;
      fv[wp] <= tlbi_vpn;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // Command outputs are loaded at pop time so they come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sweep_cnt <= '0;
      inv_valid <= 1'b0;
      inv_index <= '0;
      inv_vpn <= '0;
      inv_mask <= '0;
      ack_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state <= hk == 2'd0 ? SINGLE : SWEEP;
          sweep_cnt <= '0;
          inv_valid <= 1'b1;
          inv_index <= hk == 2'd0 ? hash : '0;
          inv_vpn <= hv & mask;
          inv_mask <= mask;
        end
        SINGLE: if (!inv_retry) begin
          state <= ACK;
          inv_valid <= 1'b0;
          inv_index <= '0;
          inv_vpn <= '0;
          inv_mask <= '0;
          ack_valid <= 1'b1;
        end
        SWEEP: if (!inv_retry) begin
          if (sweep_cnt == '1) begin
            state <= ACK;
            inv_valid <= 1'b0;
            inv_index <= '0;
            inv_vpn <= '0;
            inv_mask <= '0;
            ack_valid <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
            inv_index <= sweep_cnt + 1'b1;
          end
        end
        ACK: if (!ack_retry) begin
          state <= IDLE;
          ack_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dctlb_tlbi_seq.sv
// tb_dctlb_tlbi_seq: directed scoreboard bench for dctlb_tlbi_seq.
module tb_dctlb_tlbi_seq;
  logic clk = 0, reset = 1;
  logic tlbi_valid = 0, tlbi_retry;
  logic [1:0] tlbi_kind = 0;
  logic [26:0] tlbi_vpn = 0;
  logic inv_valid, inv_retry = 0;
  logic [5:0] inv_index;
  logic [26:0] inv_vpn, inv_mask;
  logic ack_valid, ack_retry = 0;
  typedef struct {int id; logic [5:0] idx; logic [26:0] vpn; logic [26:0] mask;} inv_t;
  inv_t inv_q[$];
  int ack_q[$];
  int vectors = 0, miscompares = 0, next_id = 0;
  logic stall_p = 0, ack_stall_p = 0;
  logic [5:0] pidx;
  logic [26:0] pvpn, pmask;
  always #5 clk = ~clk;
  dctlb_tlbi_seq dut (
    .clk(clk), .reset(reset), .tlbi_valid(tlbi_valid), .tlbi_retry(tlbi_retry),
    .tlbi_kind(tlbi_kind), .tlbi_vpn(tlbi_vpn), .inv_valid(inv_valid), .inv_retry(inv_retry),
    .inv_index(inv_index), .inv_vpn(inv_vpn), .inv_mask(inv_mask),
    .ack_valid(ack_valid), .ack_retry(ack_retry)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] hash_of(input logic [26:0] v);
    return v[5:0] ^ v[11:6] ^ v[17:12] ^ v[23:18] ^ {3'b0, v[26:24]};
  endfunction
  function automatic logic [26:0] mask_of(input logic [1:0] k);
    return k == 2'd0 ? 27'h7FFFFFF : k == 2'd1 ? 27'h7FFFE00 : k == 2'd2 ? 27'h7FFFC00 : 27'h7FC0000;
  endfunction
  task automatic expect_msg(input logic [1:0] k, input logic [26:0] v);
    inv_t e;
    e.id = next_id;
    e.mask = mask_of(k);
    e.vpn = v & e.mask;
    if (k == 2'd0) begin
      e.idx = hash_of(v);
      inv_q.push_back(e);
    end else begin
      for (int n = 0; n < 64; n++) begin
        e.idx = 6'(n);
        inv_q.push_back(e);
      end
    end
    ack_q.push_back(next_id);
    next_id++;
  endtask
  task automatic push(input logic [1:0] k, input logic [26:0] v);
    logic acc;
    acc = 0;
    expect_msg(k, v);
    tlbi_valid = 1;
    tlbi_kind = k;
    tlbi_vpn = v;
    for (int n = 0; n < 300; n++) begin
      acc = !tlbi_retry;
      @(posedge clk); #1;
      if (acc) break;
    end
    chk("push_accept", 32'(acc), 1);
    tlbi_valid = 0;
  endtask
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_index(input logic [5:0] idx, input string tag);
    logic hit;
    hit = 0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(posedge clk); #1;
      hit = inv_valid && inv_index == idx;
    end
    chk(tag, 32'(hit), 1);
  endtask
  task automatic drain(input string tag);
    logic done;
    done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge clk); #1;
      done = inv_q.size() == 0 && ack_q.size() == 0 && !ack_valid && !inv_valid;
    end
    chk(tag, 32'(done), 1);
  endtask
  always @(negedge clk) begin
    if (reset) begin
      stall_p <= 0;
      ack_stall_p <= 0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", 32'(inv_valid), 1);
        chk("stall_index", 32'(inv_index), 32'(pidx));
        chk("stall_vpn", 32'(inv_vpn), 32'(pvpn));
      end
      if (ack_stall_p) chk("ack_hold", 32'(ack_valid), 1);
      if (!inv_valid) begin
        chk("idle_index", 32'(inv_index), 0);
        chk("idle_vpn_mask", 32'(inv_vpn | inv_mask), 0);
      end else if (!inv_retry) begin
        if (inv_q.size() == 0) chk("inv_unexpected", 1, 0);
        else begin
          inv_t e;
          e = inv_q.pop_front();
          chk("inv_index", 32'(inv_index), 32'(e.idx));
          chk("inv_vpn", 32'(inv_vpn), 32'(e.vpn));
          chk("inv_mask", 32'(inv_mask), 32'(e.mask));
        end
      end
      if (ack_valid && !ack_retry) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          int id;
          id = ack_q.pop_front();
          chk("ack_after_invs", 32'(inv_q.size() == 0 || inv_q[0].id != id), 1);
        end
      end
      stall_p <= inv_valid && inv_retry;
      ack_stall_p <= ack_valid && ack_retry;
      pidx <= inv_index;
      pvpn <= inv_vpn;
      pmask <= inv_mask;
    end
  end
  initial begin
    cycles(3);
    chk("rst_tlbi_retry", 32'(tlbi_retry), 0);
    chk("rst_inv_valid", 32'(inv_valid), 0);
    chk("rst_ack_valid", 32'(ack_valid), 0);
    chk("rst_inv_index", 32'(inv_index), 0);
    chk("rst_inv_vpn_mask", 32'(inv_vpn | inv_mask), 0);
    reset = 0;
    cycles(2);
    push(2'd0, 27'h0000041);
    chk("lat_t0_inv", 32'(inv_valid), 0);
    cycles(1);
    chk("lat_t1_inv", 32'(inv_valid), 1);
    chk("lat_t1_idx", 32'(inv_index), 32'(hash_of(27'h0000041)));
    cycles(1);
    chk("lat_t2_ack", 32'(ack_valid), 1);
    cycles(1);
    chk("lat_t3_ack", 32'(ack_valid), 0);
    drain("drain_4k");
    push(2'd1, 27'h01234FF);
    wait_index(6'd10, "wait_idx10");
    inv_retry = 1;
    cycles(5);
    chk("retry_idx10", 32'(inv_index), 10);
    inv_retry = 0;
    begin
      logic hit;
      hit = 0;
      for (int n = 0; n < 300 && !hit; n++) begin
        @(posedge clk); #1;
        hit = ack_valid;
      end
      chk("wait_ack_2m", 32'(hit), 1);
    end
    ack_retry = 1;
    cycles(3);
    chk("ack_retry_hold", 32'(ack_valid), 1);
    ack_retry = 0;
    drain("drain_2m");
    ack_retry = 1;
    push(2'd0, 27'h0000100);
    cycles(4);
    chk("full_first_in_ack", 32'(ack_valid), 1);
    push(2'd0, 27'h0000200);
    push(2'd0, 27'h0003300);
    push(2'd0, 27'h0040400);
    push(2'd0, 27'h5000500);
    chk("full_retry", 32'(tlbi_retry), 1);
    cycles(2);
    chk("full_retry_held", 32'(tlbi_retry), 1);
    ack_retry = 0;
    push(2'd0, 27'h0600600);
    drain("drain_full");
    push(2'd3, 27'h7FC0123);
    push(2'd0, 27'h0000000);
    drain("drain_mixed");
    push(2'd1, 27'h0ABCDEF);
    push(2'd0, 27'h0000011);
    push(2'd0, 27'h0000022);
    wait_index(6'd20, "wait_idx20");
    reset = 1;
    cycles(1);
    reset = 0;
    inv_q.delete();
    ack_q.delete();
    chk("rst_mid_inv_valid", 32'(inv_valid), 0);
    chk("rst_mid_ack_valid", 32'(ack_valid), 0);
    chk("rst_mid_tlbi_retry", 32'(tlbi_retry), 0);
    chk("rst_mid_index", 32'(inv_index), 0);
    cycles(5);
    chk("rst_abandon_inv", 32'(inv_valid), 0);
    chk("rst_abandon_ack", 32'(ack_valid), 0);
    push(2'd0, 27'h5555555);
    drain("drain_after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
